demux_1_n_stream: RTL and testbench
===================================

DEMUX_1_N_STREAM -- requirements
Module: DEMUX_1_N_STREAM

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per data word.
REQ-002 SHALL have parameter NUM_CHANNELS, default 16: number of output channels, legal range 2..64.
REQ-003 SHALL have derived parameter SEL_WIDTH, default $clog2(NUM_CHANNELS): channel index width.
REQ-004 SHALL have port Clock_In, input, 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port Reset_In, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port Enable_In, input, 1: when low, no new word is accepted.
REQ-007 SHALL have port Mode_In, input, 1: 0 means explicit select, 1 means round-robin.
REQ-008 SHALL have ports Valid_In (input, 1) and Data_In (input, DATA_WIDTH): the upstream word and its qualifier.
REQ-009 SHALL have port Select_In, input, SEL_WIDTH: target channel in explicit mode.
REQ-010 SHALL have port Ready_Out, output, 1: upstream ready.
REQ-011 SHALL have port Data_Out, output, NUM_CHANNELS*DATA_WIDTH: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have ports Valid_Out (output, NUM_CHANNELS) and Ready_In (input, NUM_CHANNELS): per-channel handshake.
REQ-013 SHALL have ports Pointer_Out (output, SEL_WIDTH) and Error_Out (output, 1): round-robin pointer and sticky select error.

Function
REQ-014 SHALL contain one holding register (Held_Data) plus a pending mask (Pending[NUM_CHANNELS]); Valid_Out SHALL equal Pending.
REQ-015 SHALL drive lane k of Data_Out with Held_Data when Pending[k] is 1, and with zero otherwise.
REQ-016 SHALL implement two states: IDLE when Pending==0, HOLD otherwise.
REQ-017 Ready_Out SHALL equal Enable_In AND ((Pending & ~Ready_In)==0), so that full throughput of one word per cycle is possible.
REQ-018 An accept occurs when Valid_In is high and Ready_Out is high; the accepted word SHALL appear on Valid_Out and Data_Out exactly 1 cycle later.
REQ-019 Pending[k] SHALL clear in any cycle where Pending[k] and Ready_In[k] are both high; a simultaneous retire and accept SHALL load the new mask with no bubble.
REQ-020 When no accept occurs, Pending SHALL keep only bits not yet handshaken, and Held_Data SHALL remain stable.
REQ-021 In explicit mode, the target SHALL be Select_In.
REQ-022 In round-robin mode, the target SHALL be the pointer; each round-robin accept SHALL increment the pointer, wrapping from NUM_CHANNELS-1 to 0.
REQ-023 Explicit-mode accepts SHALL NOT move the pointer.
REQ-024 A change of Mode_In SHALL take effect at the next accept; held words SHALL be unaffected.
REQ-025 An explicit Select_In >= NUM_CHANNELS SHALL still be accepted, but the word SHALL be dropped (Pending stays 0 for it) and Error_Out SHALL be set and remain set until reset.
REQ-026 Enable_In low SHALL block accepts only; pending words SHALL still drain.

Reset
REQ-027 Reset_In high SHALL asynchronously force Pending=0, Held_Data=0, pointer=0, Error_Out=0, and therefore Valid_Out=0 and Data_Out=0.
REQ-028 A reset during HOLD SHALL discard the held word without completing its handshake.
REQ-029 Ready_Out SHALL be 0 while Reset_In is high.

Configuration
REQ-030 With DEMUX_BROADCAST_EN defined, the block SHALL add input Broadcast_In (1 bit); an accept with Broadcast_In=1 SHALL set every Pending bit, and the word SHALL retire only when every channel has handshaken, in any order.
REQ-031 A broadcast accept SHALL leave the pointer unchanged and SHALL never set Error_Out.
REQ-032 Without DEMUX_BROADCAST_EN, the Broadcast_In port SHALL be absent and Pending SHALL be at most one-hot.

Structure
REQ-033 Package DEMUX_Pkg SHALL hold the state enum (IDLE, HOLD) and the mode constants MODE_EXPLICIT=0 and MODE_RR=1.
REQ-034 The round-robin pointer SHALL be the sub-module DEMUX_RR_Pointer, with inputs clock, reset and advance and a SEL_WIDTH count output, parametrised by NUM_CHANNELS.

Verification
REQ-035 Reset mid-HOLD with DATA_WIDTH=8: word 0xA5 pending on channel 3, assert Reset_In -> Valid_Out=0, Data_Out=0 and Pointer_Out=0 immediately.
REQ-036 Explicit streaming with Ready_In all ones: send 0x11 to channel 2, then 0x22 to channel 7, on consecutive cycles -> Valid_Out[2] is high in cycle 1 and Valid_Out[7] in cycle 2; Ready_Out stays 1 throughout.
REQ-037 Backpressure: word 0x3C sent to channel 5 with Ready_In[5]=0 for 4 cycles -> Ready_Out=0 and Data_Out lane 5 holds 0x3C; after Ready_In[5]=1 the word retires in the same cycle and Ready_Out rises.
REQ-038 Round-robin wrap with NUM_CHANNELS=16: 17 words sent back to back -> channels 0..15, then 0; Pointer_Out=1 at the end.
REQ-039 Out-of-range select with NUM_CHANNELS=10: Select_In=12 -> word accepted, Valid_Out stays 0, Error_Out=1 and stays set; the next word to channel 9 is delivered normally.
REQ-040 Broadcast with DEMUX_BROADCAST_EN: send 0x7E with Ready_In released one channel per cycle -> Valid_Out bits clear one by one and Ready_Out=1 only after the last channel handshakes.

Source files
------------

// File: rtl/demux_1_n_stream_pkg.sv
// -----------------------------------------------------------------------------
// DEMUX_Pkg
// Shared types and constants for the 1-to-N stream demultiplexer.
//   state_e        : IDLE (nothing held) / HOLD (a word waits on one or more lanes)
//   MODE_EXPLICIT  : target lane comes from Select_In
//   MODE_RR        : target lane comes from the round-robin pointer
//   sel_in_range() : true when an explicit select addresses an existing lane
// Optional feature macro used by the block: DEMUX_BROADCAST_EN.
// -----------------------------------------------------------------------------
package DEMUX_Pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  function automatic logic sel_in_range(input int unsigned sel,
                                        input int unsigned num_channels);
    if (sel < num_channels) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/demux_1_n_stream_rr_pointer.sv
// -----------------------------------------------------------------------------
// DEMUX_RR_Pointer
// Round-robin lane pointer: advances by one on each Advance_In pulse and wraps
// from NUM_CHANNELS-1 back to 0 (also for non-power-of-two channel counts).
// Ports:
//   Clock_In   : rising-edge clock
//   Reset_In   : asynchronous active-high reset, clears the count
//   Advance_In : step the pointer this cycle
//   Count_Out  : current pointer value (registered)
// -----------------------------------------------------------------------------
module DEMUX_RR_Pointer #(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic                 Clock_In,
  input  logic                 Reset_In,
  input  logic                 Advance_In,
  output logic [SEL_WIDTH-1:0] Count_Out
);

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [SEL_WIDTH-1:0] ONE      = {{(SEL_WIDTH-1){1'b0}}, 1'b1};

  logic [SEL_WIDTH-1:0] r_count;

  // Pointer register with explicit wrap at the last implemented lane.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_count <= {SEL_WIDTH{1'b0}};
    end else if (Advance_In) begin
      if (r_count == LAST_IDX) begin
        r_count <= {SEL_WIDTH{1'b0}};
      end else begin
        r_count <= r_count + ONE;
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign Count_Out = r_count;

endmodule

// File: rtl/demux_1_n_stream.sv
// -----------------------------------------------------------------------------
// demux_1_n_stream
// Steers one upstream valid/ready stream onto NUM_CHANNELS downstream lanes.
// A single holding register plus a per-lane pending mask gives one-cycle
// latency and full one-word-per-cycle throughput.
// Ports:
//   Clock_In, Reset_In     : rising-edge clock, async active-high reset
//   Enable_In              : gates new accepts only (held words still drain)
//   Mode_In                : 0 explicit select, 1 round-robin
//   Valid_In/Data_In       : upstream word, Ready_Out its ready
//   Select_In              : explicit target lane
//   Broadcast_In           : (only with DEMUX_BROADCAST_EN) deliver to all lanes
//   Data_Out               : lane k at [k*DATA_WIDTH +: DATA_WIDTH], zero when idle
//   Valid_Out/Ready_In     : per-lane handshake
//   Pointer_Out            : round-robin pointer
//   Error_Out              : sticky flag for an out-of-range explicit select
// Optional feature macro: DEMUX_BROADCAST_EN.
// -----------------------------------------------------------------------------
module demux_1_n_stream
  import DEMUX_Pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
  input  logic                               Clock_In,
  input  logic                               Reset_In,
  input  logic                               Enable_In,
  input  logic                               Mode_In,
  input  logic                               Valid_In,
  input  logic [DATA_WIDTH-1:0]              Data_In,
  input  logic [SEL_WIDTH-1:0]               Select_In,
`ifdef DEMUX_BROADCAST_EN
  input  logic                               Broadcast_In,
`endif
  output logic                               Ready_Out,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_Out,
  output logic [NUM_CHANNELS-1:0]            Valid_Out,
  input  logic [NUM_CHANNELS-1:0]            Ready_In,
  output logic [SEL_WIDTH-1:0]               Pointer_Out,
  output logic                               Error_Out
);

  localparam logic [NUM_CHANNELS-1:0] NO_LANES  = {NUM_CHANNELS{1'b0}};
  localparam logic [NUM_CHANNELS-1:0] ALL_LANES = {NUM_CHANNELS{1'b1}};
  localparam logic [NUM_CHANNELS-1:0] LANE0     = {{(NUM_CHANNELS-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]   r_held_data;
  logic [NUM_CHANNELS-1:0] r_pending;
  logic                    r_error;

  state_e                  w_state;
  logic                    w_blocked;
  logic                    w_ready;
  logic                    w_accept;
  logic                    w_bcast;
  logic                    w_rr;
  logic                    w_in_range;
  logic                    w_drop;
  logic                    w_advance;
  logic [SEL_WIDTH-1:0]    w_pointer;
  logic [SEL_WIDTH-1:0]    w_target;
  logic [NUM_CHANNELS-1:0] w_new_mask;
  logic [NUM_CHANNELS-1:0] w_next_pending;

`ifdef DEMUX_BROADCAST_EN
  assign w_bcast = Broadcast_In;
`else
  assign w_bcast = 1'b0;
`endif

  // State is implied by the pending mask: anything outstanding means HOLD.
  always_comb begin
    if (r_pending == NO_LANES) begin
      w_state = IDLE;
    end else begin
      w_state = HOLD;
    end
  end

  // Upstream ready: a new word may enter only if every held lane retires now.
  always_comb begin
    w_blocked = ((r_pending & ~Ready_In) != NO_LANES);
    w_ready   = 1'b0;
    if (Reset_In) begin
      w_ready = 1'b0;
    end else begin
      case (w_state)
        IDLE:    w_ready = Enable_In;
        HOLD:    w_ready = Enable_In & ~w_blocked;
        default: w_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = Valid_In & w_ready;

  // Target selection and the lane mask a new word would load.
  always_comb begin
    w_rr       = (Mode_In == MODE_RR);
    w_target   = Select_In;
    w_in_range = 1'b1;
    w_new_mask = NO_LANES;
    if (w_rr) begin
      w_target   = w_pointer;
      w_in_range = 1'b1;
    end else begin
      w_target   = Select_In;
      w_in_range = sel_in_range(32'(Select_In), NUM_CHANNELS);
    end
    if (w_bcast) begin
      w_new_mask = ALL_LANES;
    end else if (w_in_range) begin
      w_new_mask = LANE0 << w_target;
    end else begin
      // Out-of-range word is consumed but never presented downstream.
      w_new_mask = NO_LANES;
    end
  end

  assign w_drop    = w_accept & ~w_bcast & ~w_in_range;
  assign w_advance = w_accept & ~w_bcast & w_rr;

  // On accept all held lanes are retiring this cycle, so the new mask replaces
  // the old one outright (no bubble); otherwise just drop handshaken lanes.
  always_comb begin
    if (w_accept) begin
      w_next_pending = w_new_mask;
    end else begin
      w_next_pending = r_pending & ~Ready_In;
    end
  end

  // Holding register, pending mask and sticky error flag.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_held_data <= {DATA_WIDTH{1'b0}};
      r_pending   <= NO_LANES;
      r_error     <= 1'b0;
    end else begin
      r_pending <= w_next_pending;
      if (w_accept) begin
        r_held_data <= Data_In;
      end else begin
        r_held_data <= r_held_data;
      end
      r_error <= r_error | w_drop;
    end
  end

  DEMUX_RR_Pointer #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .SEL_WIDTH    (SEL_WIDTH)
  ) u_rr_pointer (
    .Clock_In   (Clock_In),
    .Reset_In   (Reset_In),
    .Advance_In (w_advance),
    .Count_Out  (w_pointer)
  );

  // Each lane shows the held word only while it is pending, zero otherwise.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    assign Data_Out[k*DATA_WIDTH +: DATA_WIDTH] =
      r_pending[k] ? r_held_data : {DATA_WIDTH{1'b0}};
  end

  assign Valid_Out   = r_pending;
  assign Ready_Out   = w_ready;
  assign Pointer_Out = w_pointer;
  assign Error_Out   = r_error;

endmodule

// File: tb/tb_demux_1_n_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_1_n_stream
// Directed bench: a 16-lane instance for the main scenarios and a 10-lane
// instance for the out-of-range select case. Broadcast steps are compiled
// only when DEMUX_BROADCAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux_1_n_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en;
  // 16-lane instance
  logic         mode;
  logic         vin;
  logic [7:0]   din;
  logic [3:0]   sel;
  logic [15:0]  rdy;
  logic         ready;
  logic [127:0] dout;
  logic [15:0]  vout;
  logic [3:0]   ptr;
  logic         err;
`ifdef DEMUX_BROADCAST_EN
  logic         bcast;
`endif
  // 10-lane instance
  logic         b_mode;
  logic         b_vin;
  logic [7:0]   b_din;
  logic [3:0]   b_sel;
  logic [9:0]   b_rdy;
  logic         b_ready;
  logic [79:0]  b_dout;
  logic [9:0]   b_vout;
  logic [3:0]   b_ptr;
  logic         b_err;
`ifdef DEMUX_BROADCAST_EN
  logic         b_bcast;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(16)) dut (
    .Clock_In    (clk),
    .Reset_In    (rst),
    .Enable_In   (en),
    .Mode_In     (mode),
    .Valid_In    (vin),
    .Data_In     (din),
    .Select_In   (sel),
`ifdef DEMUX_BROADCAST_EN
    .Broadcast_In(bcast),
`endif
    .Ready_Out   (ready),
    .Data_Out    (dout),
    .Valid_Out   (vout),
    .Ready_In    (rdy),
    .Pointer_Out (ptr),
    .Error_Out   (err)
  );

  demux_1_n_stream #(.DATA_WIDTH(8), .NUM_CHANNELS(10)) dut10 (
    .Clock_In    (clk),
    .Reset_In    (rst),
    .Enable_In   (en),
    .Mode_In     (b_mode),
    .Valid_In    (b_vin),
    .Data_In     (b_din),
    .Select_In   (b_sel),
`ifdef DEMUX_BROADCAST_EN
    .Broadcast_In(b_bcast),
`endif
    .Ready_Out   (b_ready),
    .Data_Out    (b_dout),
    .Valid_Out   (b_vout),
    .Ready_In    (b_rdy),
    .Pointer_Out (b_ptr),
    .Error_Out   (b_err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] lane(input int k, input logic [7:0] v);
    return 128'(v) << (k * 8);
  endfunction

  initial begin
    rst = 1'b0; en = 1'b1;
    mode = 1'b0; vin = 1'b0; din = 8'h00; sel = 4'd0; rdy = 16'hFFFF;
    b_mode = 1'b0; b_vin = 1'b0; b_din = 8'h00; b_sel = 4'd0; b_rdy = 10'h3FF;
`ifdef DEMUX_BROADCAST_EN
    bcast = 1'b0; b_bcast = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    // reset state
    chk("rst_vout",  128'(vout),  128'h0);
    chk("rst_dout",  dout,        128'h0);
    chk("rst_ptr",   128'(ptr),   128'h0);
    chk("rst_err",   128'(err),   128'h0);
    chk("rst_ready", 128'(ready), 128'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("idle_ready", 128'(ready), 128'h1);

    // explicit streaming, back to back with retire+accept overlap
    vin = 1'b1; din = 8'h11; sel = 4'd2;
    tick();
    chk("s1_vout", 128'(vout), 128'h0004);
    chk("s1_dout", dout, lane(2, 8'h11));
    din = 8'h22; sel = 4'd7;
    #1;
    chk("s1_ready", 128'(ready), 128'h1);
    tick();
    chk("s2_vout", 128'(vout), 128'h0080);
    chk("s2_dout", dout, lane(7, 8'h22));
    chk("s2_ready", 128'(ready), 128'h1);
    vin = 1'b0;
    tick();
    chk("s3_vout", 128'(vout), 128'h0);
    chk("s3_ptr",  128'(ptr),  128'h0);

    // backpressure on lane 5
    rdy = 16'hFFDF; vin = 1'b1; din = 8'h3C; sel = 4'd5;
    tick();
    vin = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ready", 128'(ready), 128'h0);
      chk("bp_vout",  128'(vout),  128'h0020);
      chk("bp_dout",  dout,        lane(5, 8'h3C));
      tick();
    end
    rdy = 16'hFFFF;
    #1;
    chk("bp_release_ready", 128'(ready), 128'h1);
    tick();
    chk("bp_retired", 128'(vout), 128'h0);

    // enable low: held word still drains, new words blocked
    rdy = 16'hFFEF; vin = 1'b1; din = 8'h66; sel = 4'd4;
    tick();
    vin = 1'b0; en = 1'b0;
    #1;
    chk("en_ready_lo", 128'(ready), 128'h0);
    chk("en_held",     128'(vout),  128'h0010);
    rdy = 16'hFFFF;
    tick();
    chk("en_drained", 128'(vout), 128'h0);
    vin = 1'b1; din = 8'h77; sel = 4'd6;
    #1;
    chk("en_block_ready", 128'(ready), 128'h0);
    tick();
    chk("en_block_vout", 128'(vout), 128'h0);
    vin = 1'b0; en = 1'b1;
    #1;
    chk("en_back_ready", 128'(ready), 128'h1);

    // round-robin wrap: 17 words land on 0..15 then 0
    mode = 1'b1; vin = 1'b1;
    for (int i = 0; i < 17; i++) begin
      din = 8'(8'h40 + i);
      tick();
      chk("rr_vout", 128'(vout), 128'(16'h0001 << (i % 16)));
      chk("rr_dout", dout, lane(i % 16, 8'(8'h40 + i)));
      chk("rr_ptr",  128'(ptr),  128'((i + 1) % 16));
    end
    vin = 1'b0;
    tick();
    chk("rr_end_ptr", 128'(ptr), 128'h1);

    // mode change back to explicit; pointer must not move
    mode = 1'b0; vin = 1'b1; din = 8'hC3; sel = 4'd3;
    tick();
    vin = 1'b0;
    chk("mc_vout", 128'(vout), 128'h0008);
    chk("mc_ptr",  128'(ptr),  128'h1);
    tick();

    // out-of-range select on 10-lane instance
    b_vin = 1'b1; b_din = 8'h99; b_sel = 4'd12;
    #1;
    chk("oor_ready", 128'(b_ready), 128'h1);
    tick();
    chk("oor_vout", 128'(b_vout), 128'h0);
    chk("oor_dout", 128'(b_dout), 128'h0);
    chk("oor_err",  128'(b_err),  128'h1);
    b_vin = 1'b0;
    tick();
    chk("oor_err_sticky", 128'(b_err), 128'h1);
    b_vin = 1'b1; b_din = 8'h5A; b_sel = 4'd9;
    tick();
    b_vin = 1'b0;
    chk("oor_next_vout", 128'(b_vout), 128'h200);
    chk("oor_next_dout", 128'(b_dout), 128'(8'h5A) << 72);
    chk("oor_next_err",  128'(b_err),  128'h1);
    chk("main_err_clear", 128'(err), 128'h0);
    tick();

`ifdef DEMUX_BROADCAST_EN
    // broadcast: lanes released one per cycle
    rdy = 16'h0000; bcast = 1'b1; vin = 1'b1; din = 8'h7E;
    tick();
    bcast = 1'b0; vin = 1'b0;
    chk("bc_vout_all", 128'(vout), 128'hFFFF);
    chk("bc_ptr",      128'(ptr),  128'h1);
    for (int k = 0; k < 16; k++) begin
      rdy[k] = 1'b1;
      #1;
      chk("bc_ready", 128'(ready), 128'(k == 15));
      tick();
      chk("bc_vout", 128'(vout), 128'(16'hFFFF << (k + 1)));
    end
    chk("bc_err", 128'(err), 128'h0);
    rdy = 16'hFFFF;
`endif

    // reset while holding 0xA5 on lane 3
    rdy = 16'hFFF7; vin = 1'b1; din = 8'hA5; sel = 4'd3;
    tick();
    vin = 1'b0;
    chk("rh_vout_pre", 128'(vout), 128'h0008);
    chk("rh_dout_pre", dout, lane(3, 8'hA5));
    rst = 1'b1;
    #1;
    chk("rh_vout",  128'(vout),  128'h0);
    chk("rh_dout",  dout,        128'h0);
    chk("rh_ptr",   128'(ptr),   128'h0);
    chk("rh_ready", 128'(ready), 128'h0);
    chk("rh_err10", 128'(b_err), 128'h0);
    tick();
    rst = 1'b0; rdy = 16'hFFFF;
    tick();
    chk("rh_after_vout", 128'(vout), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
